video_system_key_debounce_ctrl: RTL and testbench

- Avalon-MM slave controller for the board pushbuttons (active-low KEY inputs).
- Synchronizes and debounces each key, then captures press edges into a sticky register.
- Raises a maskable interrupt for the Nios II software.
- Replaces the raw single-bit key PIO in video_system; one instance serves all keys.

---
 rtl/video_system_key_debounce_ctrl.sv | 138 +++++++++++++
 tb/tb_video_system_key_debounce_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/video_system_key_debounce_ctrl.sv
// Avalon-MM pushbutton controller: per-key synchronizer and debounce, sticky press capture, and a maskable irq.
// Optional: define KEY_RELEASE_CAPTURE_EN to also capture releases in edgecapture[2*WIDTH-1:WIDTH].
module video_system_key_debounce_ctrl #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

`ifdef KEY_RELEASE_CAPTURE_EN
  localparam int EW = 2 * WIDTH;
`else
  localparam int EW = WIDTH;
`endif

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } deb_state_t;

  logic [WIDTH-1:0] w_stable;
  logic [WIDTH-1:0] w_press;
  logic [WIDTH-1:0] w_release;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_key
      logic [1:0]       r_sync;
      logic             r_stable;
      logic [CNT_W-1:0] r_cnt;
      deb_state_t       r_state;
      logic             w_accept;

      // The accepting edge is the one where the count has reached its last value with the level still changed.
      assign w_accept      = (r_state == ST_PENDING) && (r_sync[1] != r_stable) && (r_cnt == CNT_LAST);
      assign w_press[gi]   = w_accept && r_stable;
      assign w_release[gi] = w_accept && !r_stable;
      assign w_stable[gi]  = r_stable;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_sync   <= 2'b11;
          r_stable <= 1'b1;
          r_cnt    <= '0;
          r_state  <= ST_STABLE;
        end else begin
          r_sync <= {r_sync[0], in_port[gi]};
          case (r_state)
            ST_STABLE: begin
              if (r_sync[1] != r_stable) begin
                r_cnt   <= CNT_W'(1);
                r_state <= ST_PENDING;
              end else begin
                r_cnt <= '0;
              end
            end
            ST_PENDING: begin
              if (r_sync[1] == r_stable) begin
                r_cnt   <= '0;
                r_state <= ST_STABLE;
              end else if (r_cnt == CNT_LAST) begin
                r_stable <= r_sync[1];
                r_cnt    <= '0;
                r_state  <= ST_STABLE;
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end
            default: begin
              r_cnt   <= '0;
              r_state <= ST_STABLE;
            end
          endcase
        end
      end
    end
  endgenerate

  logic          w_wr;
  logic [EW-1:0] w_ec_set;
  logic [EW-1:0] w_ec_clr;
  logic [31:0]   w_rdata;
  logic          w_unused_wdata;
  logic [EW-1:0] r_mask;
  logic [EW-1:0] r_ec;

  assign w_wr           = chipselect & ~write_n;
  assign w_unused_wdata = ^writedata;

`ifdef KEY_RELEASE_CAPTURE_EN
  assign w_ec_set = {w_release, w_press};
`else
  assign w_ec_set = w_press;
  logic w_unused_release;
  assign w_unused_release = ^w_release;
`endif

  assign w_ec_clr = (w_wr && (address == 2'd3)) ? writedata[EW-1:0] : '0;

  always_comb begin
    w_rdata = '0;
    case (address)
      2'd0:    w_rdata[WIDTH-1:0] = ~w_stable;
      2'd2:    w_rdata[EW-1:0]    = r_mask;
      2'd3:    w_rdata[EW-1:0]    = r_ec;
      default: w_rdata            = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask   <= '0;
      r_ec     <= '0;
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      if (w_wr && (address == 2'd2)) begin
        r_mask <= writedata[EW-1:0];
      end
      // Clear is applied before set so a same-cycle capture survives a write-1-to-clear.
      r_ec     <= (r_ec & ~w_ec_clr) | w_ec_set;
      readdata <= w_rdata;
      irq      <= |(r_ec & r_mask);
    end
  end

endmodule

// File: tb/tb_video_system_key_debounce_ctrl.sv
// Directed bench for video_system_key_debounce_ctrl with WIDTH=4, DEBOUNCE_CYCLES=8.
module tb_video_system_key_debounce_ctrl;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] rd;

  video_system_key_debounce_ctrl #(
    .WIDTH(4),
    .DEBOUNCE_CYCLES(8),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .in_port(in_port),
    .readdata(readdata),
    .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
    $display("check %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    tick();
    chipselect = 1'b0;
    d = readdata;
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 4'hF;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // Reset state
    check("reset_irq", {31'd0, irq}, 32'd0);
    bus_read(2'd0, rd); check("reset_data", rd, 32'h0);
    bus_read(2'd2, rd); check("reset_mask", rd, 32'h0);
    bus_read(2'd3, rd); check("reset_ec", rd, 32'h0);

    // Clean press of key0 with mask=1: capture lands on edge 10 after the step
    bus_write(2'd2, 32'h1);
    address = 2'd3;
    in_port = 4'b1110;
    repeat (9) tick();
    tick();
    check("press_ec_edge10", readdata, 32'h0);
    check("press_irq_edge10", {31'd0, irq}, 32'd0);
    tick();
    check("press_ec_edge11", readdata, 32'h1);
    check("press_irq_edge11", {31'd0, irq}, 32'd1);
    address = 2'd0;
    tick();
    check("press_data", readdata, 32'h1);

    // Release key0 and clear
    in_port = 4'hF;
    repeat (12) tick();
    bus_read(2'd0, rd); check("release0_data", rd, 32'h0);
    bus_read(2'd3, rd);
`ifdef KEY_RELEASE_CAPTURE_EN
    check("release0_ec", rd, 32'h11);
`else
    check("release0_ec", rd, 32'h1);
`endif
    bus_write(2'd3, 32'hFF);
    bus_read(2'd3, rd); check("clear_all_ec", rd, 32'h0);

    // Bounce rejection on key1
    bus_write(2'd2, 32'hF);
    for (int t = 0; t < 60; t++) begin
      in_port = (((t / 5) % 2) == 0) ? 4'b1101 : 4'b1111;
      tick();
      check("bounce_irq", {31'd0, irq}, 32'd0);
    end
    in_port = 4'hF;
    repeat (12) tick();
    check("bounce_irq_end", {31'd0, irq}, 32'd0);
    bus_read(2'd0, rd); check("bounce_data", rd, 32'h0);
    bus_read(2'd3, rd); check("bounce_ec", rd, 32'h0);

    // Clear behaviour with EDGECAPTURE=0x5
    in_port = 4'b1010;
    repeat (12) tick();
    bus_read(2'd0, rd); check("dual_data", rd, 32'h5);
    bus_read(2'd3, rd); check("dual_ec", rd, 32'h5);
    check("dual_irq", {31'd0, irq}, 32'd1);
    bus_write(2'd3, 32'h4);
    bus_read(2'd3, rd); check("clr4_ec", rd, 32'h1);
    check("clr4_irq", {31'd0, irq}, 32'd1);
    bus_write(2'd3, 32'h1);
    check("clr1_irq_same", {31'd0, irq}, 32'd1);
    tick();
    check("clr1_irq_next", {31'd0, irq}, 32'd0);
    bus_read(2'd3, rd); check("clr1_ec", rd, 32'h0);
    in_port = 4'hF;
    repeat (12) tick();
    bus_write(2'd3, 32'hFF);

    // Set/clear collision on key1: write-1-to-clear on the completing edge
    in_port = 4'b1101;
    repeat (9) tick();
    bus_write(2'd3, 32'h2);
    bus_read(2'd3, rd); check("collide_ec", rd, 32'h2);
    in_port = 4'hF;
    repeat (12) tick();
    bus_write(2'd3, 32'hFF);
    bus_read(2'd3, rd); check("collide_clr", rd, 32'h0);

    // Press then release key2
    in_port = 4'b1011;
    repeat (12) tick();
    in_port = 4'hF;
    repeat (12) tick();
    bus_read(2'd3, rd);
`ifdef KEY_RELEASE_CAPTURE_EN
    check("release2_ec", rd, 32'h44);
`else
    check("release2_ec", rd, 32'h04);
`endif
    bus_write(2'd2, 32'hFF);
    bus_read(2'd2, rd);
`ifdef KEY_RELEASE_CAPTURE_EN
    check("mask_width", rd, 32'hFF);
`else
    check("mask_width", rd, 32'h0F);
`endif
    bus_write(2'd1, 32'hFFFF_FFFF);
    bus_read(2'd1, rd); check("reserved", rd, 32'h0);
    bus_write(2'd0, 32'hFFFF_FFFF);
    bus_read(2'd0, rd); check("data_ro", rd, 32'h0);

    // Reset mid-debounce abandons the count
    in_port = 4'b0111;
    repeat (6) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    in_port = 4'hF;
    repeat (12) tick();
    bus_read(2'd0, rd); check("midreset_data", rd, 32'h0);
    bus_read(2'd3, rd); check("midreset_ec", rd, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
